ps2_rx: RTL and testbench
=========================

# ps2_rx

Receives the PS/2 keyboard serial stream on `PS2_CLK`/`PS2_DAT` and produces one 8-bit scan code per frame with a single-cycle strobe. It sits directly upstream of the keypad-entry FSMs, such as the loop-count entry block, which consume `data`/`data_en` unchanged, including 0xF0 release prefixes and E0 extended prefixes. It is host-receive only and never drives the PS/2 lines.

## Interface
Parameters:
- `FILTER_LEN`, default 4: number of consecutive identical synchronized samples needed before a filtered line level changes. Legal range 1–15.
- `TIMEOUT_CYCLES`, default 50000 (1 ms at 50 MHz): maximum number of `Clock` cycles allowed between falling edges inside a frame.

Ports:
- `Clock` in 1: system clock. All logic is on the rising edge.
- `Reset` in 1: synchronous, active-high reset.
- `PS2_CLK` in 1: raw PS/2 clock. Asynchronous to `Clock`.
- `PS2_DAT` in 1: raw PS/2 data. Asynchronous to `Clock`.
- `data` out 8: last good scan code. Holds its value until the next good frame.
- `data_en` out 1: one-cycle strobe marking a new `data` value.
- `frame_err` out 1: one-cycle strobe marking a dropped frame.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
Input conditioning:
- Each raw line passes through a 2-flop synchronizer and then a stability filter.
- A filtered level changes only after `FILTER_LEN` consecutive equal samples.
- Filtered levels reset to 1.
- A "fall event" is a cycle in which the filtered clock goes 1→0. Filtered data is sampled in that same cycle.

Frame format:
- 11 bits: start (0), D0–D7 LSB first, odd parity, stop (1).

FSM states: IDLE, DATA, PARITY, STOP.
- IDLE: on a fall event with data 0, go to DATA and clear the bit count. On a fall event with data 1, stay in IDLE silently.
- DATA: each fall event shifts the bit in at bit position `count`. After the 8th bit, go to PARITY.
- PARITY: the fall event captures the parity bit, then go to STOP.
- STOP: the fall event ends the frame and the FSM returns to IDLE.
  - If stop=1 and the parity check passes, load `data` and pulse `data_en`.
  - Otherwise, pulse `frame_err` and leave `data` unchanged.
- Parity passes when XOR(D0..D7, parity bit) = 1.

Watchdog:
- A counter clears on every fall event and in IDLE, and increments otherwise.
- If it reaches `TIMEOUT_CYCLES` while the FSM is not in IDLE:
  - pulse `frame_err`;
  - return to IDLE and discard any partial bits.
- The counter saturates and never wraps.

Boundary conditions:
- A timeout and a fall event in the same cycle: the fall event wins and the counter clears.
- `Reset` mid-frame: all state is discarded. The next frame must begin with a fresh start bit.
- The shift register width is exactly 8 bits. No byte assembly or break-code interpretation happens here.

## Timing
- Reset values: `data`=0x00, `data_en`=0, `frame_err`=0, `busy`=0, FSM=IDLE, filtered lines=1.
- Input latency: a raw edge reaches the filtered level 2 + `FILTER_LEN` cycles after it is first sampled.
- Output timing: for a stop-bit fall event in cycle F, `data`/`data_en`/`frame_err` are registered at the end of F. They are visible in F+1.
- `data_en` and `frame_err` are high for exactly one cycle per frame and are never high together.
- `data` is stable from F+1 until the next `data_en`.
- `busy` rises the cycle after the start-bit fall event and falls the cycle after the stop-bit or timeout event.
- Minimum PS/2 clock low/high time supported: (`FILTER_LEN`+1) `Clock` cycles.

## Configuration
Macro: `PS2_RX_PARITY_CHECK_EN`.
- Defined: parity is enforced exactly as described under Operation.
- Undefined:
  - the parity bit is captured but ignored;
  - a frame with stop=1 always produces `data_en`;
  - `frame_err` comes only from a bad stop bit or a timeout.

## Test plan
1. Frames 0x1C (parity 0), 0xF0 (parity 1), 0x1C, sent at 12.5 kHz with a 50 MHz clock → three `data_en` pulses carrying 0x1C, 0xF0, 0x1C. `frame_err` stays 0.
2. Frame 0x16 sent with parity 1 (wrong) → with the macro: `frame_err` pulse, no `data_en`, `data` keeps its previous value. Without the macro: `data_en` with 0x16.
3. Frame 0x5A sent with stop bit 0 → `frame_err` pulse and no `data_en`. A following good 0x45 frame → `data_en` with 0x45.
4. Frame abandoned after 5 data bits, then an idle gap longer than `TIMEOUT_CYCLES` → one `frame_err` at the timeout and `busy` drops. A following 0x66 frame is received correctly.
5. `PS2_CLK` glitches low for `FILTER_LEN`−1 cycles during a 0x3D frame → glitches ignored and `data_en` with 0x3D.
6. `Reset` asserted for 1 cycle mid-frame (after bit D3), then a full 0x26 frame → no output from the aborted frame, outputs return to reset values, then `data_en` with 0x26.

Source files
------------

// File: rtl/ps2_rx.sv
// ============================================================================
// Module   : ps2_rx
// Function : PS/2 host-side receiver. It synchronises and filters the raw
//            lines, then outputs one 8-bit scan code per 11-bit frame.
// Config   : define PS2_RX_PARITY_CHECK_EN to enforce odd parity.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_rx #(
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] data,
    output logic       data_en,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [3:0]        c_FILT_LAST = 4'(FILTER_LEN - 1);
    localparam int                c_WD_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_WD_W-1:0] c_WD_MAX    = c_WD_W'(TIMEOUT_CYCLES);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_DATA   = 2'd1;
    localparam logic [1:0] c_PARITY = 2'd2;
    localparam logic [1:0] c_STOP   = 2'd3;

    // Bit 0 carries the clock line and bit 1 carries the data line.
    logic [1:0] w_raw;
    logic [1:0] w_filt;
    assign w_raw = {PS2_DAT, PS2_CLK};

    for (genvar i = 0; i < 2; i++) begin : g_filt
        logic       r_s1;
        logic       r_s2;
        logic       r_lvl;
        logic [3:0] r_cnt;

        // The level flips only after FILTER_LEN consecutive samples that
        // disagree with it; any agreeing sample restarts the run.
        always_ff @(posedge Clock) begin
            if (Reset) begin
                r_s1  <= 1'b1;
                r_s2  <= 1'b1;
                r_lvl <= 1'b1;
                r_cnt <= '0;
            end else begin
                r_s1 <= w_raw[i];
                r_s2 <= r_s1;
                if (r_s2 == r_lvl) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_FILT_LAST) begin
                    r_lvl <= r_s2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 4'd1;
                end
            end
        end

        assign w_filt[i] = r_lvl;
    end

    logic              r_clk_d;
    logic [1:0]        r_state;
    logic [2:0]        r_count;
    logic [7:0]        r_shift;
    logic [c_WD_W-1:0] r_wd;
    logic              w_fall;
    logic              w_bit;
    logic              w_par_ok;

    assign w_fall = r_clk_d & ~w_filt[0];
    assign w_bit  = w_filt[1];
    assign busy   = (r_state != c_IDLE);

`ifdef PS2_RX_PARITY_CHECK_EN
    logic r_par;
    assign w_par_ok = ^{r_shift, r_par};
`else
    assign w_par_ok = 1'b1;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_clk_d   <= 1'b1;
            r_state   <= c_IDLE;
            r_count   <= '0;
            r_shift   <= '0;
            r_wd      <= '0;
            data      <= '0;
            data_en   <= 1'b0;
            frame_err <= 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
            r_par     <= 1'b0;
`endif
        end else begin
            r_clk_d   <= w_filt[0];
            data_en   <= 1'b0;
            frame_err <= 1'b0;

            if (r_state == c_IDLE || w_fall) begin
                r_wd <= '0;
            end else if (r_wd != c_WD_MAX) begin
                r_wd <= r_wd + 1'b1;
            end

            case (r_state)
                c_IDLE: begin
                    if (w_fall && !w_bit) begin
                        r_state <= c_DATA;
                        r_count <= '0;
                        r_shift <= '0;
                    end
                end
                c_DATA: begin
                    if (w_fall) begin
                        r_shift[r_count] <= w_bit;
                        r_count          <= r_count + 3'd1;
                        if (r_count == 3'd7) begin
                            r_state <= c_PARITY;
                        end
                    end
                end
                c_PARITY: begin
                    if (w_fall) begin
`ifdef PS2_RX_PARITY_CHECK_EN
                        r_par   <= w_bit;
`endif
                        r_state <= c_STOP;
                    end
                end
                default: begin
                    if (w_fall) begin
                        r_state <= c_IDLE;
                        if (w_bit && w_par_ok) begin
                            data    <= r_shift;
                            data_en <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
            endcase

            // A fall event in the same cycle takes precedence over the timeout.
            if (r_state != c_IDLE && !w_fall && r_wd == c_WD_MAX) begin
                r_state   <= c_IDLE;
                frame_err <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ps2_rx.sv
// ============================================================================
// Module   : tb_ps2_rx
// Function : Self-checking bench for ps2_rx. It sends directed and random
//            frames and checks them against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_rx;

    localparam int FILTER_LEN     = 4;
    localparam int TIMEOUT_CYCLES = 200;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       PS2_CLK = 1'b1;
    logic       PS2_DAT = 1'b1;
    logic [7:0] data;
    logic       data_en;
    logic       frame_err;
    logic       busy;

    int n_cmp = 0;
    int n_mis = 0;
    int n_en  = 0;
    int n_err = 0;
    logic [7:0] model_data = 8'h00;

    ps2_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .PS2_CLK   (PS2_CLK),
        .PS2_DAT   (PS2_DAT),
        .data      (data),
        .data_en   (data_en),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge Clock) begin
        if (data_en)   n_en++;
        if (frame_err) n_err++;
        if (data_en || frame_err) check("excl", 32'(data_en & frame_err), 32'd0);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic send_bit(input logic b, input int h, input bit glitch);
        if (glitch) begin
            tick(3);
            PS2_CLK = 1'b0;
            tick(FILTER_LEN - 1);
            PS2_CLK = 1'b1;
            tick(3);
        end
        PS2_DAT = b;
        tick(h);
        PS2_CLK = 1'b0;
        tick(h);
        PS2_CLK = 1'b1;
    endtask

    // The reference outcome is derived from the frame contents alone.
    function automatic bit frame_good(input logic [7:0] d, input logic p, input logic stop);
`ifdef PS2_RX_PARITY_CHECK_EN
        return stop && ((($countones(d) + int'(p)) % 2) == 1);
`else
        return stop;
`endif
    endfunction

    task automatic do_frame(input logic [7:0] d, input bit bad_par, input logic stop, input bit glitch);
        int   en0, er0, h;
        logic p;
        bit   good;
        en0  = n_en;
        er0  = n_err;
        h    = $urandom_range(FILTER_LEN + 2, 25);
        p    = logic'((($countones(d) % 2) == 0) ^ bad_par);
        good = frame_good(d, p, stop);
        send_bit(1'b0, h, glitch);
        for (int i = 0; i < 8; i++) send_bit(d[i], h, glitch);
        send_bit(p, h, glitch);
        send_bit(stop, h, glitch);
        PS2_DAT = 1'b1;
        tick(h + 20);
        if (good) model_data = d;
        @(negedge Clock);
        check($sformatf("en_cnt_%02h", d), 32'(n_en - en0), 32'(good));
        check($sformatf("err_cnt_%02h", d), 32'(n_err - er0), 32'(!good));
        check($sformatf("data_%02h", d), 32'(data), 32'(model_data));
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        int en0, er0;
        logic [7:0] d;
        tick(4);
        @(negedge Clock);
        check("rst_data", 32'(data), 32'h00);
        check("rst_en", 32'(data_en), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        Reset = 1'b0;
        tick(10);

        do_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        do_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        do_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        do_frame(8'h16, 1'b1, 1'b1, 1'b0);
        do_frame(8'h5A, 1'b0, 1'b0, 1'b0);
        do_frame(8'h45, 1'b0, 1'b1, 1'b0);

        // Abandoned frame: start and five data bits, then silence.
        en0 = n_en;
        er0 = n_err;
        d   = 8'h66;
        send_bit(1'b0, 10, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(d[i], 10, 1'b0);
        PS2_DAT = 1'b1;
        tick(10);
        @(negedge Clock);
        check("to_busy_mid", 32'(busy), 32'd1);
        tick(TIMEOUT_CYCLES + 100);
        @(negedge Clock);
        check("to_err", 32'(n_err - er0), 32'd1);
        check("to_en", 32'(n_en - en0), 32'd0);
        check("to_busy", 32'(busy), 32'd0);
        do_frame(8'h66, 1'b0, 1'b1, 1'b0);

        do_frame(8'h3D, 1'b0, 1'b1, 1'b1);

        // Reset after D3 of a frame, then a clean frame.
        en0 = n_en;
        er0 = n_err;
        d   = 8'h26;
        send_bit(1'b0, 10, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i], 10, 1'b0);
        tick(3);
        PS2_DAT = 1'b1;
        Reset   = 1'b1;
        tick(1);
        Reset   = 1'b0;
        model_data = 8'h00;
        @(negedge Clock);
        check("mr_data", 32'(data), 32'h00);
        check("mr_busy", 32'(busy), 32'd0);
        tick(40);
        @(negedge Clock);
        check("mr_en", 32'(n_en - en0), 32'd0);
        check("mr_err", 32'(n_err - er0), 32'd0);
        do_frame(8'h26, 1'b0, 1'b1, 1'b0);

        for (int k = 0; k < 12; k++) begin
            do_frame(8'($urandom), ($urandom_range(0, 4) == 0),
                     logic'($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
